had_trace_cnt: RTL and testbench

- Parametrised trace-mode retire counter for the HAD debug unit. Successor to the single-slot trace-decrement enable.
- Counts instructions that retire normally while trace is armed. Supports up to two retire slots per cycle and a selectable multi-load/store counting policy.
- Raises a held debug-mode request when the programmed count expires. Sits between IU retire signals and the HAD control/debug-request logic.

---
 rtl/had_trace_cnt_if.sv | 33 +++
 rtl/had_trace_cnt.sv | 107 ++++++++++
 tb/tb_had_trace_cnt.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/had_trace_cnt_if.sv
// Connects the HAD trace retire counter to its register and retire sources.
// The master modport drives the counter's inputs and the slave modport is the counter itself.
interface had_trace_cnt_if #(
  parameter int CNT_WIDTH = 8,
  parameter int RETIRE_W  = 1
);
  logic                 regs_trace_en;
  logic                 regs_trace_cnt_wen;
  logic [CNT_WIDTH-1:0] regs_trace_cnt_wdata;
  logic [RETIRE_W-1:0]  iu_had_xx_retire;
  logic [RETIRE_W-1:0]  iu_had_xx_retire_normal;
  logic [RETIRE_W-1:0]  iu_had_xx_mldst;
  logic                 iu_yy_xx_dbgon;
  logic                 had_core_dbg_mode_req;
  logic                 trace_cnt_dec;
  logic [CNT_WIDTH-1:0] trace_cnt_val;
  logic                 trace_dbg_req;
  logic                 trace_expired;

  modport master (
    output regs_trace_en, regs_trace_cnt_wen, regs_trace_cnt_wdata,
           iu_had_xx_retire, iu_had_xx_retire_normal, iu_had_xx_mldst,
           iu_yy_xx_dbgon, had_core_dbg_mode_req,
    input  trace_cnt_dec, trace_cnt_val, trace_dbg_req, trace_expired
  );

  modport slave (
    input  regs_trace_en, regs_trace_cnt_wen, regs_trace_cnt_wdata,
           iu_had_xx_retire, iu_had_xx_retire_normal, iu_had_xx_mldst,
           iu_yy_xx_dbgon, had_core_dbg_mode_req,
    output trace_cnt_dec, trace_cnt_val, trace_dbg_req, trace_expired
  );
endinterface

// File: rtl/had_trace_cnt.sv
// Trace-mode retire down-counter: counts qualified retires while trace is armed and
// raises a held debug request when the programmed count runs out.
//
//   state | meaning
//   IDLE  | counter holds, no request
//   COUNT | trace armed, qualified retires decrement the counter
//   REQ   | count expired, trace_dbg_req held until debug entry or trace disable
module had_trace_cnt #(
  parameter int CNT_WIDTH   = 8,
  parameter int RETIRE_W    = 1,
  parameter int MLDST_COUNT = 0
) (
  input logic            cpuclk,
  input logic            cpurst_b,
  had_trace_cnt_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    REQ   = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 dbg_req;
  logic                 expired;
  logic                 en_q;

  logic [RETIRE_W-1:0]  qual;
  logic                 eligible;
  logic [CNT_WIDTH-1:0] dec_amt;

  assign qual = bus.iu_had_xx_retire & bus.iu_had_xx_retire_normal &
                ((MLDST_COUNT != 0) ? {RETIRE_W{1'b1}} : ~bus.iu_had_xx_mldst);

  assign eligible = bus.regs_trace_en && !bus.iu_yy_xx_dbgon &&
                    !bus.had_core_dbg_mode_req && (state == COUNT);

  always_comb begin
    dec_amt = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      dec_amt = dec_amt + CNT_WIDTH'(qual[i]);
    end
    if (!eligible) begin
      dec_amt = '0;
    end
  end

  // A same-cycle software write wins, so its decrement never lands.
  assign bus.trace_cnt_dec = (dec_amt != '0) && !bus.regs_trace_cnt_wen;
  assign bus.trace_cnt_val = cnt;
  assign bus.trace_dbg_req = dbg_req;
  assign bus.trace_expired = expired;

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state   <= IDLE;
      cnt     <= '0;
      dbg_req <= 1'b0;
      expired <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      en_q <= bus.regs_trace_en;
      if (bus.regs_trace_cnt_wen) begin
        cnt     <= bus.regs_trace_cnt_wdata;
        expired <= 1'b0;
        dbg_req <= 1'b0;
        state   <= ((bus.regs_trace_cnt_wdata != '0) && bus.regs_trace_en) ? COUNT : IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.regs_trace_en && !en_q && (cnt != '0)) begin
              state <= COUNT;
            end
          end
          COUNT: begin
            if (!bus.regs_trace_en) begin
              state <= IDLE;
            end else if (dec_amt != '0) begin
              // Saturate at zero: a dual retire with one count left must not wrap.
              if (cnt > dec_amt) begin
                cnt <= cnt - dec_amt;
              end else begin
                cnt     <= '0;
                state   <= REQ;
                dbg_req <= 1'b1;
                expired <= 1'b1;
              end
            end
          end
          REQ: begin
            if (bus.iu_yy_xx_dbgon || !bus.regs_trace_en) begin
              state   <= IDLE;
              dbg_req <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            dbg_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_had_trace_cnt.sv
// Bench for had_trace_cnt: a dual-slot instance (mldst ignored) and a single-slot instance
// (mldst counted) share stimulus; a behavioural model feeds per-cycle expectations to a scoreboard.
module tb_had_trace_cnt;

  logic cpuclk;
  logic cpurst_b;

  had_trace_cnt_if #(.CNT_WIDTH(8), .RETIRE_W(2)) bus_a ();
  had_trace_cnt_if #(.CNT_WIDTH(8), .RETIRE_W(1)) bus_b ();

  had_trace_cnt #(.CNT_WIDTH(8), .RETIRE_W(2), .MLDST_COUNT(0)) dut_a (
    .cpuclk(cpuclk), .cpurst_b(cpurst_b), .bus(bus_a.slave));
  had_trace_cnt #(.CNT_WIDTH(8), .RETIRE_W(1), .MLDST_COUNT(1)) dut_b (
    .cpuclk(cpuclk), .cpurst_b(cpurst_b), .bus(bus_b.slave));

  initial begin
    cpuclk = 1'b0;
    forever #5 cpuclk = ~cpuclk;
  end

  typedef struct packed {
    logic [7:0] val;
    logic       dec;
    logic       req;
    logic       expd;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int total = 0;
  int bad   = 0;

  // Model: count left, whether trace is armed, whether a request is pending.
  int cnt_m[2];
  bit armed_m[2];
  bit req_m[2];
  bit expd_m[2];
  bit en_prev_m[2];

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, want);
    end
  endtask

  always @(negedge cpuclk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_val", int'(bus_a.trace_cnt_val), int'(e.val));
      chk("a_dec", int'(bus_a.trace_cnt_dec), int'(e.dec));
      chk("a_req", int'(bus_a.trace_dbg_req), int'(e.req));
      chk("a_expired", int'(bus_a.trace_expired), int'(e.expd));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_val", int'(bus_b.trace_cnt_val), int'(e.val));
      chk("b_dec", int'(bus_b.trace_cnt_dec), int'(e.dec));
      chk("b_req", int'(bus_b.trace_dbg_req), int'(e.req));
      chk("b_expired", int'(bus_b.trace_expired), int'(e.expd));
    end
  end

  task automatic drive(input bit en, input bit wen, input int wdata, input bit [1:0] ret,
                       input bit [1:0] norm, input bit [1:0] mld, input bit dbg, input bit core);
    bus_a.regs_trace_en           = en;
    bus_a.regs_trace_cnt_wen      = wen;
    bus_a.regs_trace_cnt_wdata    = 8'(wdata);
    bus_a.iu_had_xx_retire        = ret;
    bus_a.iu_had_xx_retire_normal = norm;
    bus_a.iu_had_xx_mldst         = mld;
    bus_a.iu_yy_xx_dbgon          = dbg;
    bus_a.had_core_dbg_mode_req   = core;
    bus_b.regs_trace_en           = en;
    bus_b.regs_trace_cnt_wen      = wen;
    bus_b.regs_trace_cnt_wdata    = 8'(wdata);
    bus_b.iu_had_xx_retire        = ret[0];
    bus_b.iu_had_xx_retire_normal = norm[0];
    bus_b.iu_had_xx_mldst         = mld[0];
    bus_b.iu_yy_xx_dbgon          = dbg;
    bus_b.had_core_dbg_mode_req   = core;
  endtask

  task automatic step(input bit en, input bit wen, input int wdata, input bit [1:0] ret,
                      input bit [1:0] norm, input bit [1:0] mld, input bit dbg, input bit core);
    @(posedge cpuclk);
    #1;
    cpurst_b = 1'b1;
    drive(en, wen, wdata, ret, norm, mld, dbg, core);
    for (int k = 0; k < 2; k++) begin
      int slots;
      int n;
      bit counts_mldst;
      bit may_dec;
      exp_t e;
      slots        = (k == 0) ? 2 : 1;
      counts_mldst = (k == 1);
      n = 0;
      for (int s = 0; s < slots; s++) begin
        if (ret[s] && norm[s] && (counts_mldst || !mld[s])) n++;
      end
      may_dec = armed_m[k] && en && !dbg && !core && (n > 0);
      e.val  = 8'(cnt_m[k]);
      e.dec  = may_dec && !wen;
      e.req  = req_m[k];
      e.expd = expd_m[k];
      if (k == 0) qa.push_back(e); else qb.push_back(e);

      if (wen) begin
        cnt_m[k]   = wdata % 256;
        expd_m[k]  = 1'b0;
        req_m[k]   = 1'b0;
        armed_m[k] = (cnt_m[k] != 0) && en;
      end else if (armed_m[k]) begin
        if (!en) begin
          armed_m[k] = 1'b0;
        end else if (may_dec) begin
          if (cnt_m[k] > n) begin
            cnt_m[k] = cnt_m[k] - n;
          end else begin
            cnt_m[k]   = 0;
            armed_m[k] = 1'b0;
            req_m[k]   = 1'b1;
            expd_m[k]  = 1'b1;
          end
        end
      end else if (req_m[k]) begin
        if (dbg || !en) req_m[k] = 1'b0;
      end else if (en && !en_prev_m[k] && cnt_m[k] != 0) begin
        armed_m[k] = 1'b1;
      end
      en_prev_m[k] = en;
    end
  endtask

  // Reset lands between clock edges; the following negedge sees outputs before any edge.
  task automatic rst_cycle(input bit [1:0] ret);
    exp_t e;
    @(posedge cpuclk);
    #1;
    drive(1'b1, 1'b0, 0, ret, ret, 2'b00, 1'b0, 1'b0);
    cpurst_b = 1'b0;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      cnt_m[k] = 0; armed_m[k] = 0; req_m[k] = 0; expd_m[k] = 0; en_prev_m[k] = 0;
    end
    qa.push_back(e);
    qb.push_back(e);
  endtask

  initial begin
    cpurst_b = 1'b1;
    drive(0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    rst_cycle(2'b00);
    step(0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    step(0, 0, 0, 2'b01, 2'b01, 2'b00, 0, 0);
    // write 3, three single retires, expiry and request
    step(1, 1, 3, 2'b00, 2'b00, 2'b00, 0, 0);
    repeat (3) step(1, 0, 0, 2'b01, 2'b01, 2'b00, 0, 0);
    repeat (2) step(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    step(1, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    step(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    // mldst retire: ignored by a, counted by b
    step(1, 1, 2, 2'b00, 2'b00, 2'b00, 0, 0);
    step(1, 0, 0, 2'b01, 2'b01, 2'b01, 0, 0);
    step(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    // dual retire at count 1 saturates, then 5 -> 3
    step(1, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0);
    step(1, 0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
    step(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    step(1, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    step(1, 1, 5, 2'b00, 2'b00, 2'b00, 0, 0);
    step(1, 0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
    step(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    // write beats a same-cycle retire
    step(1, 1, 4, 2'b00, 2'b00, 2'b00, 0, 0);
    step(1, 1, 9, 2'b11, 2'b11, 2'b00, 0, 0);
    step(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    // blocked by pending debug request or debug mode
    step(1, 0, 0, 2'b11, 2'b11, 2'b00, 0, 1);
    step(1, 0, 0, 2'b11, 2'b11, 2'b00, 1, 0);
    step(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    // write 0 drops to idle, retires ignored
    step(1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    step(1, 0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
    // reset mid-count, then retires ignored until a nonzero write
    step(1, 1, 6, 2'b00, 2'b00, 2'b00, 0, 0);
    step(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    rst_cycle(2'b01);
    repeat (3) step(1, 0, 0, 2'b01, 2'b01, 2'b00, 0, 0);
    // load while disabled, then enable rising edge arms counting
    step(0, 1, 5, 2'b00, 2'b00, 2'b00, 0, 0);
    step(0, 0, 0, 2'b01, 2'b01, 2'b00, 0, 0);
    step(1, 0, 0, 2'b01, 2'b01, 2'b00, 0, 0);
    repeat (2) step(1, 0, 0, 2'b01, 2'b01, 2'b00, 0, 0);
    step(0, 0, 0, 2'b01, 2'b01, 2'b00, 0, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit en, wen, dbg, core;
      int wdata;
      en    = ($urandom_range(0, 11) != 0);
      wen   = ($urandom_range(0, 9) == 0);
      wdata = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 6));
      dbg   = ($urandom_range(0, 7) == 0);
      core  = ($urandom_range(0, 9) == 0);
      step(en, wen, wdata, 2'($urandom), 2'($urandom_range(1, 3)), 2'($urandom_range(0, 3) == 0),
           dbg, core);
    end
    step(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    repeat (2) @(negedge cpuclk);
    chk("drain", qa.size() + qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
